box_position_ctrl: RTL

Frame-synchronous position controller for the on-screen rectangle in the VGA path. Samples the four active-low direction buttons once per N vertical blanking intervals and moves the rectangle by a fixed step, clamped to the visible area. Drives the rectangle bounds consumed by the pixel display stage. All bound updates land inside vertical blanking, so a frame never shows a partially moved box.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/axis_step.sv | 55 +++++
 rtl/box_position_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared VGA screen constants, coordinate width and the
//           position-controller FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;
  localparam int STATE_W  = 2;

  localparam logic [1:0] S_ACTIVE = 2'd0;
  localparam logic [1:0] S_STEP   = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/axis_step.sv
// ============================================================================
// Module  : axis_step
// Purpose : Next coordinate along one axis. Out-of-range moves clamp, or wrap
//           when BOX_POSITION_CTRL_WRAP_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_step
  import vga_pkg::*;
#(
  parameter int STEP = 2,
  parameter int LIM  = 576
) (
  input  logic [COORD_W-1:0] i_v,
  input  logic               i_dec,
  input  logic               i_inc,
  output logic [COORD_W-1:0] o_v_next,
  output logic               o_changed
);

`ifdef BOX_POSITION_CTRL_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  localparam logic [COORD_W:0] STEP_X = (COORD_W + 1)'(STEP);
  localparam logic [COORD_W:0] LIM_X  = (COORD_W + 1)'(LIM);

  logic [COORD_W:0] v_ext;
  logic [COORD_W:0] sum;
  logic [COORD_W:0] diff;
  logic [COORD_W:0] v_next_x;

  // One extra bit so that both underflow and overflow past LIM are visible.
  always_comb begin
    v_ext    = {1'b0, i_v};
    sum      = v_ext + STEP_X;
    diff     = v_ext - STEP_X;
    v_next_x = v_ext;
    if (i_dec) begin
      if (v_ext < STEP_X) v_next_x = WRAP ? LIM_X : '0;
      else                v_next_x = diff;
    end else if (i_inc) begin
      if (sum > LIM_X) v_next_x = WRAP ? '0 : LIM_X;
      else             v_next_x = sum;
    end
    o_v_next  = v_next_x[COORD_W-1:0];
    o_changed = (v_next_x != v_ext);
  end

endmodule

`default_nettype wire

// File: rtl/box_position_ctrl.sv
// ============================================================================
// Module  : box_position_ctrl
// Purpose : Moves the on-screen rectangle by STEP once per FRAME_DIV vertical
//           blanks; BOX_POSITION_CTRL_WRAP_EN selects wrap instead of clamp.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module box_position_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BOX_W     = 64,
  parameter int BOX_H     = 64,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1,
  parameter int INIT_X    = 288,
  parameter int INIT_Y    = 208
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        up,
  input  logic                        down,
  input  logic                        left,
  input  logic                        right,
  input  logic                        vnotactive,
  output logic [vga_pkg::COORD_W-1:0] topX,
  output logic [vga_pkg::COORD_W-1:0] topY,
  output logic [vga_pkg::COORD_W-1:0] endX,
  output logic [vga_pkg::COORD_W-1:0] endY,
  output logic                        moved
);

  import vga_pkg::*;

  localparam int FCNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(FRAME_DIV - 1);
  localparam logic [COORD_W-1:0] X0        = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] Y0        = COORD_W'(INIT_Y);
  localparam logic [COORD_W-1:0] BOX_W_M1  = COORD_W'(BOX_W - 1);
  localparam logic [COORD_W-1:0] BOX_H_M1  = COORD_W'(BOX_H - 1);

  // Button vector order: {up, down, left, right}; all active-low.
  logic [3:0]         btn_meta_q, btn_meta_d;
  logic [3:0]         btn_sync_q, btn_sync_d;
  logic               vna_q, vna_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W-1:0] end_x_q, end_x_d;
  logic [COORD_W-1:0] end_y_q, end_y_d;
  logic               moved_q, moved_d;

  logic               blank_start;
  logic [COORD_W-1:0] x_next, y_next;
  logic               x_chg, y_chg;

  assign blank_start = vnotactive & ~vna_q;

  axis_step #(
    .STEP (STEP),
    .LIM  (SCREEN_W - BOX_W)
  ) u_axis_x (
    .i_v       (x_q),
    .i_dec     (~btn_sync_q[1]),
    .i_inc     (~btn_sync_q[0]),
    .o_v_next  (x_next),
    .o_changed (x_chg)
  );

  axis_step #(
    .STEP (STEP),
    .LIM  (SCREEN_H - BOX_H)
  ) u_axis_y (
    .i_v       (y_q),
    .i_dec     (~btn_sync_q[3]),
    .i_inc     (~btn_sync_q[2]),
    .o_v_next  (y_next),
    .o_changed (y_chg)
  );

  always_comb begin
    btn_meta_d = {up, down, left, right};
    btn_sync_d = btn_meta_q;
    vna_d      = vnotactive;
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    x_d        = x_q;
    y_d        = y_q;
    end_x_d    = end_x_q;
    end_y_d    = end_y_q;
    moved_d    = 1'b0;
    case (state_q)
      S_ACTIVE: begin
        if (blank_start) begin
          if (fcnt_q == FCNT_LAST) begin
            fcnt_d  = '0;
            state_d = S_STEP;
          end else begin
            fcnt_d  = fcnt_q + FCNT_W'(1);
            state_d = S_HOLD;
          end
        end
      end
      S_STEP: begin
        x_d     = x_next;
        y_d     = y_next;
        end_x_d = x_next + BOX_W_M1;
        end_y_d = y_next + BOX_H_M1;
        moved_d = x_chg | y_chg;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!vnotactive) state_d = S_ACTIVE;
      end
      default: state_d = S_ACTIVE;
    endcase
  end

  // vna_q resets high so a reset released mid-blank cannot trigger a step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_meta_q <= 4'hF;
      btn_sync_q <= 4'hF;
      vna_q      <= 1'b1;
      state_q    <= S_ACTIVE;
      fcnt_q     <= '0;
      x_q        <= X0;
      y_q        <= Y0;
      end_x_q    <= X0 + BOX_W_M1;
      end_y_q    <= Y0 + BOX_H_M1;
      moved_q    <= 1'b0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      vna_q      <= vna_d;
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      end_x_q    <= end_x_d;
      end_y_q    <= end_y_d;
      moved_q    <= moved_d;
    end
  end

  assign topX  = x_q;
  assign topY  = y_q;
  assign endX  = end_x_q;
  assign endY  = end_y_q;
  assign moved = moved_q;

endmodule

`default_nettype wire
